// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
// State encoding, bus widths and timeout counter sizing.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_CYC = 16;

    function automatic int tmo_cnt_w(input int cyc);
        return $clog2(cyc + 1);
    endfunction

    localparam int APB_TMO_CNT_W = tmo_cnt_w(APB_TIMEOUT_CYC);

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request -> APB3 master bridge, one transfer in flight.
// Define APB_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT_CYC cycles.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state_q, state_d;

    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                // PREADY wins over a timeout landing on the same cycle
                if (PREADY) begin
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    rerr_d    = PSLVERR;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    state_d   = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    rdata_d   = '0;
                    rerr_d    = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed transfers,
// wait states, slave error, backpressure, reset abort, timeout.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic psel_prev = 1'b0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each handshake.
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, want none",
                         rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    // APB ordering: PENABLE only with PSEL, never in the first PSEL cycle.
    always @(negedge PCLK) begin
        if (PENABLE === 1'b1) begin
            chk("penable_needs_psel", 64'(PSEL), 64'd1);
            chk("penable_not_first", 64'(psel_prev), 64'd1);
        end
        psel_prev = PSEL;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // From IDLE: present a request, check acceptance and the SETUP cycle.
    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge PCLK);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("setup_psel", 64'(PSEL), 64'd1);
        chk("setup_penable", 64'(PENABLE), 64'd0);
        chk("setup_paddr", 64'(PADDR), 64'(a));
        chk("setup_pwrite", 64'(PWRITE), 64'(wr));
        chk("setup_pwdata", 64'(PWDATA), wr ? 64'(d) : 64'd0);
        step();
    endtask

    // n ACCESS cycles; PREADY high only in cycle rdy_at (0 = never).
    task automatic access(input int n, input int rdy_at,
                          input logic [31:0] a, input logic [31:0] wd);
        for (int i = 1; i <= n; i++) begin
            PREADY = (i == rdy_at);
            @(negedge PCLK);
            chk("access_psel", 64'(PSEL), 64'd1);
            chk("access_penable", 64'(PENABLE), 64'd1);
            chk("access_paddr", 64'(PADDR), 64'(a));
            chk("access_pwdata", 64'(PWDATA), 64'(wd));
            step();
        end
        PREADY = 1'b0;
    endtask

    // First RESP cycle with rsp_ready high, then back to IDLE.
    task automatic rsp_done();
        @(negedge PCLK);
        chk("resp_valid", 64'(rsp_valid), 64'd1);
        chk("resp_psel", 64'(PSEL), 64'd0);
        chk("resp_penable", 64'(PENABLE), 64'd0);
        step();
        @(negedge PCLK);
        chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("after_req_ready", 64'(req_ready), 64'd1);
        step();
    endtask

    initial begin
        PRESETN   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (2) step();
        @(negedge PCLK);
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        step();
        PRESETN = 1'b1;

        // Write, zero wait states (PREADY also high during SETUP).
        PREADY = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        issue(1'b1, 32'h0000_0010, 32'hA5A5_1234);
        access(1, 1, 32'h0000_0010, 32'hA5A5_1234);
        rsp_done();

        // Read with three wait states.
        PRDATA = 32'hDEAD_BEEF;
        exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        issue(1'b0, 32'h0000_0004, 32'h1111_2222);
        access(4, 4, 32'h0000_0004, 32'h0);
        rsp_done();

        // Slave error plus response backpressure.
        PRDATA    = 32'h1234_5678;
        PSLVERR   = 1'b1;
        rsp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b1});
        issue(1'b0, 32'h0000_0008, 32'h0);
        access(1, 1, 32'h0000_0008, 32'h0);
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0BAD_0BAD;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h0000_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
            chk("hold_rsp_err", 64'(rsp_err), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_psel", 64'(PSEL), 64'd0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        @(negedge PCLK);
        chk("err_idle_req_ready", 64'(req_ready), 64'd1);
        chk("err_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("err_paddr_kept", 64'(PADDR), 64'h8);
        chk("err_idle_psel", 64'(PSEL), 64'd0);
        step();

        // Reset while ACCESS is stalled: transfer is dropped.
        issue(1'b0, 32'h0000_000C, 32'h0);
        access(2, 0, 32'h0000_000C, 32'h0);
        PRESETN = 1'b0;
        step();
        @(negedge PCLK);
        chk("abort_psel", 64'(PSEL), 64'd0);
        chk("abort_penable", 64'(PENABLE), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        step();
        PRESETN = 1'b1;
        PREADY  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        PREADY = 1'b0;

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: exactly 16 ACCESS cycles then error.
        PRDATA = 32'hFFFF_FFFF;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        issue(1'b0, 32'h0000_0020, 32'h0);
        access(16, 0, 32'h0000_0020, 32'h0);
        rsp_done();

        // PREADY on the 16th cycle: normal completion wins.
        PRDATA = 32'hCAFE_F00D;
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        issue(1'b0, 32'h0000_0024, 32'h0);
        access(16, 16, 32'h0000_0024, 32'h0);
        rsp_done();
`endif

        repeat (3) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
